// File: rtl/apb_uart_pkg.sv
// apb_uart_pkg: shared constants and state encoding for the UART receiver.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package apb_uart_pkg;

  localparam int unsigned OS_RATE           = 8;
  localparam int unsigned START_SAMPLE_TICK = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_os_tick_gen.sv
// uart_os_tick_gen: one-cycle oversample tick every max(div,1) clocks,
// restartable so the tick phase can be aligned to a detected start edge.
module uart_os_tick_gen #(
  parameter int unsigned DIV_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] last;

  // Terminal count (div of 0 behaves like 1) and counter next value.
  always_comb begin
    last  = (div == '0) ? '0 : div - DIV_WIDTH'(1);
    tick  = !restart && (cnt_q == last);
    cnt_d = cnt_q + DIV_WIDTH'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  // Divider counter register.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1/8N2 UART receiver, 8x oversampled, with ready/valid output
// register and one-cycle parity/frame/overrun pulses.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int unsigned CLK_DIV_WIDTH = 32,
  parameter int unsigned OS_RATE       = apb_uart_pkg::OS_RATE
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     rx_i,
  input  logic [CLK_DIV_WIDTH-1:0] clk_div_i,
  input  logic                     parity_en_i,
  input  logic                     parity_odd_i,
  input  logic                     two_stop_i,
  output logic [7:0]               rx_data_o,
  output logic                     rx_data_valid_o,
  input  logic                     rx_data_ready_i,
  output logic                     parity_error_o,
  output logic                     frame_error_o,
  output logic                     overrun_o
);

  import apb_uart_pkg::*;

  localparam int unsigned TICK_W = $clog2(OS_RATE);
  localparam logic [TICK_W-1:0] START_LAST = TICK_W'(START_SAMPLE_TICK - 1);
  localparam logic [TICK_W-1:0] BIT_LAST   = TICK_W'(OS_RATE - 1);

  uart_rx_state_e state_q, state_d;

  logic [1:0]               rx_sync_q, rx_sync_d;
  logic                     rx_s;
  logic                     armed_q, armed_d;
  logic [TICK_W-1:0]        bit_tick_q, bit_tick_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic                     stop_cnt_q, stop_cnt_d;
  logic [7:0]               shift_q, shift_d;
  logic                     frm_err_q, frm_err_d;
  logic                     two_stop_q, two_stop_d;
  logic [CLK_DIV_WIDTH-1:0] div_q, div_d;
  logic [7:0]               data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     fe_q, fe_d;
  logic                     ov_q, ov_d;
  logic                     os_tick;
  logic                     start_det;
  logic                     fe_now;
  logic                     last_stop;

`ifdef UART_RX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_odd_q, par_odd_d;
  logic par_err_q, par_err_d;
  logic pe_q, pe_d;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = parity_en_i ^ parity_odd_i;
`endif

  assign rx_s      = rx_sync_q[1];
  assign start_det = (state_q == IDLE) && armed_q && !rx_s;

  uart_os_tick_gen #(
    .DIV_WIDTH(CLK_DIV_WIDTH)
  ) u_tick (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .restart(start_det),
    .div    (div_q),
    .tick   (os_tick)
  );

  // Next-state, datapath and completion resolution.
  always_comb begin
    rx_sync_d  = {rx_sync_q[0], rx_i};
    state_d    = state_q;
    // A start edge needs the line to have been seen high while idle, so a
    // low tail after a stop sample is not mistaken for a new start.
    armed_d    = (state_q == IDLE) && (armed_q || rx_s);
    bit_tick_d = bit_tick_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    frm_err_d  = frm_err_q;
    two_stop_d = two_stop_q;
    div_d      = div_q;
    data_d     = data_q;
    valid_d    = valid_q && !rx_data_ready_i;
    fe_d       = 1'b0;
    ov_d       = 1'b0;
    fe_now     = frm_err_q || !rx_s;
    last_stop  = !two_stop_q || stop_cnt_q;
`ifdef UART_RX_PARITY_EN
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    par_err_d  = par_err_q;
    pe_d       = 1'b0;
`endif

    if (os_tick) begin
      bit_tick_d = (bit_tick_q == BIT_LAST) ? '0 : bit_tick_q + TICK_W'(1);
    end

    case (state_q)
      IDLE: begin
        bit_tick_d = '0;
        if (start_det) begin
          state_d    = START;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          frm_err_d  = 1'b0;
          two_stop_d = two_stop_i;
          div_d      = clk_div_i;
`ifdef UART_RX_PARITY_EN
          par_en_d   = parity_en_i;
          par_odd_d  = parity_odd_i;
          par_err_d  = 1'b0;
`endif
        end
      end

      START: begin
        if (os_tick && (bit_tick_q == START_LAST)) begin
          bit_tick_d = '0;
          state_d    = rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (os_tick && (bit_tick_q == BIT_LAST)) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (os_tick && (bit_tick_q == BIT_LAST)) begin
          par_err_d = (rx_s != ((^shift_q) ^ par_odd_q));
          state_d   = STOP;
        end
      end
`endif

      STOP: begin
        if (os_tick && (bit_tick_q == BIT_LAST)) begin
          if (last_stop) begin
            state_d = IDLE;
            // Registering the resolution makes the pulses and valid appear
            // in the first IDLE cycle. A same-cycle handshake frees the slot.
            if (fe_now) begin
              fe_d = 1'b1;
            end else if (valid_q && !rx_data_ready_i) begin
              ov_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
              pe_d    = par_err_q;
`endif
            end
          end else begin
            stop_cnt_d = 1'b1;
            frm_err_d  = fe_now;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      rx_sync_q  <= '1;
      armed_q    <= 1'b0;
      bit_tick_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      frm_err_q  <= 1'b0;
      two_stop_q <= 1'b0;
      div_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      par_err_q  <= 1'b0;
      pe_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rx_sync_q  <= rx_sync_d;
      armed_q    <= armed_d;
      bit_tick_q <= bit_tick_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      frm_err_q  <= frm_err_d;
      two_stop_q <= two_stop_d;
      div_q      <= div_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      par_err_q  <= par_err_d;
      pe_q       <= pe_d;
`endif
    end
  end

  assign rx_data_o       = data_q;
  assign rx_data_valid_o = valid_q;
  assign frame_error_o   = fe_q;
  assign overrun_o       = ov_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error_o  = pe_q;
`else
  assign parity_error_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Expected bytes are queued as
// frames are driven and popped on each output handshake.
module tb_uart_rx;

  localparam int unsigned CLK_DIV_WIDTH = 32;
`ifdef UART_RX_PARITY_EN
  localparam int PE_EXP = 1;
`else
  localparam int PE_EXP = 0;
`endif

  logic                     clk_i = 1'b0;
  logic                     srst_i;
  logic                     rx_i;
  logic [CLK_DIV_WIDTH-1:0] clk_div_i;
  logic                     parity_en_i;
  logic                     parity_odd_i;
  logic                     two_stop_i;
  logic [7:0]               rx_data_o;
  logic                     rx_data_valid_o;
  logic                     rx_data_ready_i;
  logic                     parity_error_o;
  logic                     frame_error_o;
  logic                     overrun_o;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  exp_q[$];
  int          pe_seen = 0;
  int          pe_lone = 0;
  int          fe_seen = 0;
  int          ov_seen = 0;
  int          cyc_cnt = 0;
  int          rise_cyc = 0;
  logic        prev_valid = 1'b0;
  int          bit_cycles = 32;

  uart_rx #(
    .CLK_DIV_WIDTH(CLK_DIV_WIDTH),
    .OS_RATE      (8)
  ) dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .rx_i           (rx_i),
    .clk_div_i      (clk_div_i),
    .parity_en_i    (parity_en_i),
    .parity_odd_i   (parity_odd_i),
    .two_stop_i     (two_stop_i),
    .rx_data_o      (rx_data_o),
    .rx_data_valid_o(rx_data_valid_o),
    .rx_data_ready_i(rx_data_ready_i),
    .parity_error_o (parity_error_o),
    .frame_error_o  (frame_error_o),
    .overrun_o      (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc_cnt++;

  // Output monitor: pulse accounting and scoreboard pop on handshake.
  always @(negedge clk_i) begin
    logic [7:0] exp;
    if (!srst_i) begin
      if (parity_error_o) pe_seen++;
      if (parity_error_o && !rx_data_valid_o) pe_lone++;
      if (frame_error_o) fe_seen++;
      if (overrun_o) ov_seen++;
      if (rx_data_valid_o && !prev_valid) rise_cyc = cyc_cnt;
      if (rx_data_valid_o && rx_data_ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_byte: got %02h, expected no byte", rx_data_o);
        end else begin
          exp = exp_q.pop_front();
          if (rx_data_o !== exp)
            $display("FAIL rx_byte: got %02h, expected %02h", rx_data_o, exp);
          else
            n_pass++;
        end
      end
    end
    prev_valid = rx_data_valid_o;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic set_div(input int d);
    clk_div_i  = CLK_DIV_WIDTH'(d);
    bit_cycles = 8 * ((d == 0) ? 1 : d);
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    cyc(bit_cycles);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input bit par_bit,
                            input bit two, input bit s0, input bit s1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (has_par) drive_bit(par_bit);
    drive_bit(s0);
    if (two) drive_bit(s1);
    rx_i = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      cyc(1);
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL %s_drain: %0d bytes outstanding, expected 0", name, exp_q.size());
    else
      n_pass++;
  endtask

  task automatic test_reset;
    srst_i = 1'b1;
    rx_i = 1'b1;
    cyc(4);
    n_checks++;
    if (rx_data_valid_o !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", rx_data_valid_o);
    else n_pass++;
    n_checks++;
    if (rx_data_o !== 8'h00) $display("FAIL reset_data: got %02h, expected 00", rx_data_o);
    else n_pass++;
    n_checks++;
    if ({parity_error_o, frame_error_o, overrun_o} !== 3'b000)
      $display("FAIL reset_pulses: got %b, expected 000", {parity_error_o, frame_error_o, overrun_o});
    else n_pass++;
    srst_i = 1'b0;
    cyc(4);
  endtask

  task automatic test_basic;
    int t0, pe0, fe0, ov0, lat;
    set_div(4);
    pe0 = pe_seen; fe0 = fe_seen; ov0 = ov_seen;
    exp_q.push_back(8'hA5);
    t0 = cyc_cnt;
    send_frame(8'hA5, 0, 0, 0, 1, 1);
    drive_bit(1'b1);
    wait_drain("basic", 200);
    lat = rise_cyc - t0;
    n_checks++;
    if (lat < 300 || lat > 312) $display("FAIL basic_latency: got %0d cycles, expected 300..312", lat);
    else n_pass++;
    n_checks++;
    if ({pe_seen - pe0, fe_seen - fe0, ov_seen - ov0} !== {32'd0, 32'd0, 32'd0})
      $display("FAIL basic_pulses: got pe=%0d fe=%0d ov=%0d, expected 0 0 0",
               pe_seen - pe0, fe_seen - fe0, ov_seen - ov0);
    else n_pass++;
  endtask

  task automatic test_parity;
    int pe0, lone0;
    parity_en_i = 1'b1;
    parity_odd_i = 1'b0;
    pe0 = pe_seen; lone0 = pe_lone;
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1, 1, 0, 1, 1);
    drive_bit(1'b1);
    wait_drain("parity_even", 200);
    n_checks++;
    if (pe_seen - pe0 != PE_EXP) $display("FAIL parity_even_pulse: got %0d, expected %0d", pe_seen - pe0, PE_EXP);
    else n_pass++;
    n_checks++;
    if (pe_lone != lone0) $display("FAIL parity_with_valid: got %0d lone pulses, expected 0", pe_lone - lone0);
    else n_pass++;
    parity_odd_i = 1'b1;
    pe0 = pe_seen;
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1, 1, 0, 1, 1);
    drive_bit(1'b1);
    wait_drain("parity_odd", 200);
    n_checks++;
    if (pe_seen != pe0) $display("FAIL parity_odd_pulse: got %0d, expected 0", pe_seen - pe0);
    else n_pass++;
    parity_en_i = 1'b0;
    parity_odd_i = 1'b0;
  endtask

  task automatic test_frame_error;
    int fe0;
    fe0 = fe_seen;
    send_frame(8'h55, 0, 0, 0, 0, 1);
    drive_bit(1'b1);
    n_checks++;
    if (fe_seen - fe0 != 1) $display("FAIL frame_err_pulse: got %0d, expected 1", fe_seen - fe0);
    else n_pass++;
    n_checks++;
    if (rx_data_valid_o !== 1'b0) $display("FAIL frame_err_valid: got %b, expected 0", rx_data_valid_o);
    else n_pass++;
  endtask

  task automatic test_two_stop;
    int fe0;
    two_stop_i = 1'b1;
    fe0 = fe_seen;
    send_frame(8'h3C, 0, 0, 1, 1, 0);
    drive_bit(1'b1);
    n_checks++;
    if (fe_seen - fe0 != 1) $display("FAIL two_stop_err: got %0d, expected 1", fe_seen - fe0);
    else n_pass++;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 0, 0, 1, 1, 1);
    drive_bit(1'b1);
    wait_drain("two_stop", 200);
    two_stop_i = 1'b0;
  endtask

  task automatic test_overrun;
    int ov0;
    rx_data_ready_i = 1'b0;
    ov0 = ov_seen;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 0, 0, 0, 1, 1);
    drive_bit(1'b1);
    send_frame(8'h22, 0, 0, 0, 1, 1);
    drive_bit(1'b1);
    n_checks++;
    if (rx_data_o !== 8'h11 || rx_data_valid_o !== 1'b1)
      $display("FAIL overrun_hold: got data=%02h valid=%b, expected 11 1", rx_data_o, rx_data_valid_o);
    else n_pass++;
    n_checks++;
    if (ov_seen - ov0 != 1) $display("FAIL overrun_pulse: got %0d, expected 1", ov_seen - ov0);
    else n_pass++;
    rx_data_ready_i = 1'b1;
    cyc(1);
    n_checks++;
    if (rx_data_valid_o !== 1'b0) $display("FAIL overrun_release: got valid=%b, expected 0", rx_data_valid_o);
    else n_pass++;
    wait_drain("overrun", 10);
  endtask

  task automatic test_glitch;
    int fe0, ov0, pe0;
    fe0 = fe_seen; ov0 = ov_seen; pe0 = pe_seen;
    rx_i = 1'b0;
    cyc(8);
    rx_i = 1'b1;
    cyc(200);
    n_checks++;
    if (rx_data_valid_o !== 1'b0 || fe_seen != fe0 || ov_seen != ov0 || pe_seen != pe0)
      $display("FAIL glitch_quiet: got valid=%b fe=%0d ov=%0d pe=%0d, expected 0 0 0 0",
               rx_data_valid_o, fe_seen - fe0, ov_seen - ov0, pe_seen - pe0);
    else n_pass++;
    exp_q.push_back(8'h96);
    send_frame(8'h96, 0, 0, 0, 1, 1);
    drive_bit(1'b1);
    wait_drain("after_glitch", 200);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    int fe0, ov0;
    d = 8'hC6;
    fe0 = fe_seen; ov0 = ov_seen;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx_i = d[3];
    cyc(bit_cycles / 2);
    srst_i = 1'b1;
    rx_i = 1'b1;
    cyc(3);
    n_checks++;
    if ({rx_data_o, rx_data_valid_o, parity_error_o, frame_error_o, overrun_o} !== 12'h000)
      $display("FAIL midreset_outputs: got data=%02h v=%b pe=%b fe=%b ov=%b, expected all 0",
               rx_data_o, rx_data_valid_o, parity_error_o, frame_error_o, overrun_o);
    else n_pass++;
    srst_i = 1'b0;
    cyc(bit_cycles * 12);
    n_checks++;
    if (rx_data_valid_o !== 1'b0 || fe_seen != fe0 || ov_seen != ov0)
      $display("FAIL midreset_abort: got valid=%b fe=%0d ov=%0d, expected 0 0 0",
               rx_data_valid_o, fe_seen - fe0, ov_seen - ov0);
    else n_pass++;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 0, 0, 0, 1, 1);
    drive_bit(1'b1);
    wait_drain("after_reset", 200);
  endtask

  task automatic test_back_to_back;
    set_div(0);
    drive_bit(1'b1);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hFF);
    send_frame(8'hC3, 0, 0, 0, 1, 1);
    send_frame(8'h5A, 0, 0, 0, 1, 1);
    send_frame(8'hFF, 0, 0, 0, 1, 1);
    drive_bit(1'b1);
    wait_drain("back_to_back", 100);
    set_div(4);
  endtask

  initial begin
    srst_i = 1'b1;
    rx_i = 1'b1;
    clk_div_i = CLK_DIV_WIDTH'(4);
    parity_en_i = 1'b0;
    parity_odd_i = 1'b0;
    two_stop_i = 1'b0;
    rx_data_ready_i = 1'b1;
    test_reset();
    test_basic();
    test_parity();
    test_frame_error();
    test_two_stop();
    test_overrun();
    test_glitch();
    test_reset_mid_frame();
    test_back_to_back();
    cyc(20);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_DIV_WIDTH, default 32, width of the oversample divider input.
REQ-002 SHALL have parameter OS_RATE, default 8, oversample ticks per bit; fixed at 8 in this revision.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port srst_i  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port clk_div_i  input  CLK_DIV_WIDTH  clk_i cycles per oversample tick; 0 treated as 1.
REQ-007 SHALL have port parity_en_i  input  1  parity bit present after data.
REQ-008 SHALL have port parity_odd_i  input  1  1 selects odd parity, 0 selects even parity.
REQ-009 SHALL have port two_stop_i  input  1  1 selects two stop bits, 0 selects one.
REQ-010 SHALL have port rx_data_o  output  8  received byte.
REQ-011 SHALL have port rx_data_valid_o  output  1  byte available.
REQ-012 SHALL have port rx_data_ready_i  input  1  consumer (RX FIFO) accepts byte.
REQ-013 SHALL have port parity_error_o  output  1  one-cycle pulse, parity mismatch.
REQ-014 SHALL have port frame_error_o  output  1  one-cycle pulse, stop bit sampled low.
REQ-015 SHALL have port overrun_o  output  1  one-cycle pulse, frame dropped because output was full.

Function
REQ-016 SHALL pass rx_i through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-017 SHALL generate a one-cycle os_tick every max(clk_div_i,1) cycles; the divider SHALL restart at 0 on start-edge detection.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; the reset state SHALL be IDLE.
REQ-019 IDLE: a synchronized 1->0 transition SHALL move the FSM to START.
REQ-020 START: on the 4th tick the FSM SHALL sample the line; high SHALL return to IDLE (false start, no output); low SHALL move to DATA.
REQ-021 DATA: each bit SHALL be sampled 8 ticks after the previous sample; 8 bits, LSB first, shifted into an 8-bit register.
REQ-022 PARITY: entered only if parity_en_i; expected bit = XOR(data) XOR parity_odd_i; a mismatch sets an internal flag.
REQ-023 STOP: one or two stop samples at 8-tick spacing per two_stop_i; any low stop sample SHALL set frame error.
REQ-024 Completion: the cycle after the final stop sample, the FSM SHALL return to IDLE and resolve the frame as follows, in priority order:
  - Frame error: pulse frame_error_o; discard the byte.
  - Output register full: pulse overrun_o; discard the byte.
  - Otherwise: load rx_data_o, assert rx_data_valid_o, and pulse parity_error_o if the parity flag is set; the byte is still delivered.
REQ-025 Handshake: rx_data_valid_o SHALL stay high and rx_data_o stable until a cycle with rx_data_ready_i high; valid drops the next cycle.
REQ-026 Simultaneous handshake and completion in the same cycle: the register counts as free, and the new byte SHALL load with valid staying high.
REQ-027 Configuration inputs SHALL be sampled at start detection and held for the whole frame.
REQ-028 After a stop sample, a low line SHALL be detected as a new start edge once the line has been seen high in IDLE.

Reset
REQ-029 srst_i SHALL force the FSM to IDLE, clear the divider, shift register and flags, set rx_data_o=0, and set all valid and pulse outputs to 0; the synchronizer SHALL preset to 1.
REQ-030 Reset mid-frame SHALL abort the frame with no output or pulse.

Configuration
REQ-031 Macro UART_RX_PARITY_EN: when defined, REQ-022 applies.
REQ-032 When UART_RX_PARITY_EN is undefined: parity_en_i and parity_odd_i are ignored, the PARITY state is absent, and parity_error_o is tied to 0.

Structure
REQ-033 The package apb_uart_pkg SHALL hold the uart_rx_state_e enum and the OS_RATE and START_SAMPLE_TICK (4) constants.
REQ-034 The tick divider SHALL be the sub-module uart_os_tick_gen (inputs clk_i, srst_i, restart, div; output tick).

Verification
REQ-035 clk_div_i=4, no parity, one stop, send 0xA5 -> rx_data_o=0xA5 with valid high about 304 cycles after the start edge; no error pulses.
REQ-036 Parity enabled and even, send 0x03 with parity bit 1 -> byte 0x03 delivered together with a one-cycle parity_error_o pulse.
REQ-037 Stop bit driven low, send 0x55 -> frame_error_o pulses; valid stays low.
REQ-038 ready held 0, send 0x11 then 0x22 -> rx_data_o stays 0x11 and overrun_o pulses once; ready=1 then drops valid.
REQ-039 Low glitch of 2 ticks in IDLE -> FSM returns to IDLE; no output.
REQ-040 srst_i asserted during DATA bit 3 -> all outputs 0; the next clean frame 0x7E is received correctly.
